// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions.
// One quotient bit is produced per CALC cycle; FIX applies the signs and selects the
// output. Divide-by-zero and signed overflow skip CALC and resolve in FIX directly.
//
// Ports:
//   clk_i      rising-edge clock
//   reset_i    synchronous active-high reset (abandons any in-flight operation)
//   start_i    request pulse, accepted only in IDLE or DONE
//   div_op_i   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a_i, b_i   dividend (rs1) and divisor (rs2)
//   busy_o     high during CALC and FIX
//   done_o     one-cycle pulse when result_o becomes valid
//   result_o   quotient or remainder, held until overwritten by the next operation
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       div_op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MinInt = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q;
  logic            rem_sel_q;   // 1: return remainder, 0: quotient
  logic            neg_quo_q;   // signed op with differing operand signs
  logic            neg_rem_q;   // signed op with negative dividend
  logic            special_q;   // result already final, skip sign fixups
  logic [WIDTH-1:0] dvd_q;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CntW-1:0]  count_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  // Operand decode for a new request
  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             div_zero, ovf;

  always_comb begin
    signed_op = ~div_op_i[0];
    a_neg     = signed_op & a_i[WIDTH-1];
    b_neg     = signed_op & b_i[WIDTH-1];
    a_abs     = a_neg ? (~a_i + 1'b1) : a_i;
    b_abs     = b_neg ? (~b_i + 1'b1) : b_i;
    div_zero  = (b_i == '0);
    ovf       = signed_op && (a_i == MinInt) && (&b_i);
  end

  // One restoring step; WIDTH+1 bits so a divisor with its MSB set loses no carry
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   rem_step;
  logic             q_bit;

  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    q_bit    = (shifted >= {1'b0, dvs_q});
    rem_step = q_bit ? (shifted - {1'b0, dvs_q}) : shifted;
  end

  // Sign correction applied in FIX
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    quo_fix = (!special_q && neg_quo_q) ? (~dvd_q + 1'b1) : dvd_q;
    rem_fix = (!special_q && neg_rem_q) ? (~rem_q + 1'b1) : rem_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      special_q <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            rem_sel_q <= div_op_i[1];
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            count_q   <= '0;
            busy_q    <= 1'b1;
            if (div_zero) begin
              // quotient all ones, remainder is the raw dividend
              special_q <= 1'b1;
              dvd_q     <= '1;
              rem_q     <= a_i;
              state_q   <= StFix;
            end else if (ovf) begin
              special_q <= 1'b1;
              dvd_q     <= MinInt;
              rem_q     <= '0;
              state_q   <= StFix;
            end else begin
              special_q <= 1'b0;
              dvd_q     <= a_abs;
              dvs_q     <= b_abs;
              rem_q     <= '0;
              state_q   <= StCalc;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StCalc: begin
          rem_q   <= rem_step[WIDTH-1:0];
          dvd_q   <= {dvd_q[WIDTH-2:0], q_bit};
          count_q <= count_q + CntW'(1);
          if (count_q == CntW'(WIDTH - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          result_q <= rem_sel_q ? rem_fix : quo_fix;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed results and latencies for signed and
// unsigned divide/remainder, divide-by-zero, signed overflow, ignored restart and reset.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   div_op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_err = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (start),
    .div_op_i (div_op),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge and follow it to done (bounded wait).
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] exp_res, input int exp_lat);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; div_op = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    check({tag, "_busy1"}, {31'b0, busy}, 32'd1);
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_busycnt"}, busy_cnt, exp_lat - 1);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    int done_cnt;
    int done_cyc;
    logic [W-1:0] done_res;

    reset = 1'b1; start = 1'b0; div_op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b0;

    run_op("div_m20_3", 2'b00, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34);
    run_op("rem_m20_3", 2'b10, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34);
    run_op("div_20_m3", 2'b00, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 34);
    run_op("rem_20_m3", 2'b10, 32'd20, 32'hFFFF_FFFD, 32'd2, 34);
    run_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 34);
    run_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 34);
    run_op("remu_1000_7", 2'b11, 32'd1000, 32'd7, 32'd6, 34);
    run_op("div_by0", 2'b00, 32'd7, 32'd0, 32'hFFFF_FFFF, 2);
    run_op("rem_by0", 2'b10, 32'd7, 32'd0, 32'd7, 2);
    run_op("remu_by0", 2'b11, 32'h8000_0000, 32'd0, 32'h8000_0000, 2);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

    // Restart while busy must be ignored
    @(negedge clk);
    start = 1'b1; div_op = 2'b01; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; done_cnt = 0; done_cyc = 0; done_res = '0;
    while (cyc < 60) begin
      if (cyc == 5) begin
        start = 1'b1; div_op = 2'b00; a = 32'd100; b = 32'd10;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_res = result;
      end
      @(negedge clk);
      cyc++;
    end
    check("ign_done_cnt", done_cnt, 32'd1);
    check("ign_done_cyc", done_cyc, 32'd34);
    check("ign_res", done_res, 32'd142);

    // Reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; div_op = 2'b01; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    reset = 1'b0;
    done_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("mid_rst_no_done", done_cnt, 32'd0);
    run_op("divu_9_2", 2'b01, 32'd9, 32'd2, 32'd4, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
